bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential, parametrised binary-to-BCD converter for display digit drivers.
//   Converts an unsigned DATA_W-bit value to DIGITS packed BCD digits by shift-add-3 (double dabble), one bit per clock.
//   Uses a start/busy/done handshake and adds overflow detection and leading-zero blanking flags.
//   Sits between the datapath result bus and the seven-segment digit decoders.
// PARAMETERS
//   DATA_W   32  width of binary input, >=1
//   DIGITS   4   number of BCD digits produced, >=1; digit 0 = least significant
//   BLANK_LZ 1   1: generate leading-zero blank flags; 0: blank[] tied to 0
// PORTS
//   in_clk    in   1           clock, rising-edge
//   rst       in   1           asynchronous reset, active-low
//   start     in   1           request conversion of data; sampled only when ready=1
//   data      in   DATA_W      unsigned binary operand, captured on accepted start
//   ready     out  1           1 in IDLE: start will be accepted
//   busy      out  1           1 while a conversion is in progress (= !ready)
//   done      out  1           single-cycle pulse: bcd/blank/overflow just updated
//   bcd       out  4*DIGITS    packed digits; bcd[4i+3:4i] = digit i, each 0..9
//   blank     out  DIGITS      blank[i]=1: digit i is a leading zero (blank[0] always 0)
//   overflow  out  1           1: last converted value >= 10**DIGITS
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, bcd=0, blank=0, overflow=0, done=0, ready=1, busy=0,
//     internal shift/scratch registers and bit counter cleared. Reset mid-conversion aborts it; no done.
//   States: IDLE -> SHIFT -> FINISH -> IDLE.
//   IDLE: on edge with start=1: load binary shift reg <= data, BCD scratch <= 0, ovf scratch <= 0,
//     count <= 0, go SHIFT. start=0: stay. data ignored except at accepted start.
//   SHIFT, each edge: for each scratch digit >=5 add 3 (all digits in parallel, same cycle),
//     then shift {scratch, binary} left one bit; bit leaving scratch MSB ORed into ovf scratch.
//     count increments; after DATA_W shifts (count==DATA_W-1 on that edge) go FINISH.
//   FINISH (one cycle): bcd <= scratch, overflow <= ovf scratch, blank <= computed flags,
//     done <= 1, go IDLE. done is 1 for exactly the following cycle only.
//   Latency: start accepted at edge k -> outputs updated and done=1 after edge k+DATA_W+1.
//     Throughput: one conversion per DATA_W+2 cycles (start may be re-asserted in the done cycle).
//   ready=1 only in IDLE; start while busy is ignored, not queued. Holding start high
//     restarts immediately on each return to IDLE.
//   bcd/blank/overflow hold last result between conversions; not updated during SHIFT.
//   Overflow: value >= 10**DIGITS -> overflow=1 and bcd = value mod 10**DIGITS
//     (low digits exact; carries beyond top digit discarded).
//   Blanking (BLANK_LZ=1): blank[i]=1 iff i>0 and digits i..DIGITS-1 all zero, evaluated on
//     the new result; if overflow=1, blank=0 (all digits shown). Value 0 -> only digit 0 unblanked.
//   Counter width: clog2(DATA_W+1) bits; DATA_W=1 gives one SHIFT cycle.
//   Scratch register is 4*DIGITS bits; no internal state exceeds this plus DATA_W.
// TESTING
//   1. rst=0 mid-conversion (DATA_W=32) -> all outputs 0, ready=1 immediately; no done pulse follows.
//   2. data=1234, start 1 cycle -> after 33 edges done=1 one cycle, bcd=16'h1234, overflow=0, blank=4'b0000.
//   3. data=7 -> bcd=16'h0007, blank=4'b1110; data=0 -> bcd=0, blank=4'b1110, overflow=0.
//   4. data=9999 -> bcd=16'h9999, overflow=0; data=10000 -> bcd=16'h0000, overflow=1, blank=0;
//      data=32'hFFFFFFFF -> bcd=16'h7295, overflow=1.
//   5. start pulsed during SHIFT with new data -> ignored; result matches first operand; start held
//      high -> back-to-back conversions every 34 cycles, each with single-cycle done.
//   6. DIGITS=10, DATA_W=32, BLANK_LZ=0: data=32'hFFFFFFFF -> bcd=40'h4294967295, overflow=0, blank=0;
//      random 10k values vs reference model value%10**DIGITS.

Source files
------------

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (double dabble, one bit
//                per clock) with start/busy/done handshake, overflow flag
//                and leading-zero blank flags for seven-segment drivers.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  in_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     data,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(DATA_W - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [DATA_W-1:0]    r_bin;
    logic [4*DIGITS-1:0]  r_scr;
    logic                 r_ovf_scr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_done;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [DIGITS-1:0]    r_blank;
    logic                 r_overflow;

    logic                 w_load;
    logic                 w_shift;
    logic                 w_finish;
    logic [4*DIGITS-1:0]  w_adj;
    logic [DIGITS-1:0]    w_blank;

    // State register; async reset aborts any conversion in flight
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> SHIFT (DATA_W cycles) -> FINISH -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (start) w_next_state = c_SHIFT;
            c_SHIFT:  if (r_cnt == c_LAST_CNT) w_next_state = c_FINISH;
            c_FINISH: w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Handshake outputs and datapath strobes decoded from the current state
    always_comb begin
        ready    = (r_state == c_IDLE);
        busy     = (r_state != c_IDLE);
        w_load   = (r_state == c_IDLE) && start;
        w_shift  = (r_state == c_SHIFT);
        w_finish = (r_state == c_FINISH);
    end

    // Add-3 correction applied to every scratch digit in parallel before the shift
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_scr[4*gi +: 4] >= 4'd5) ?
                                      (r_scr[4*gi +: 4] + 4'd3) : r_scr[4*gi +: 4];
        end
    endgenerate

    // Leading-zero flags: digit i is blank when it and every digit above are zero;
    // an overflowed result shows all digits since the upper digits are truncated
    generate
        if (BLANK_LZ != 0) begin : g_blank_on
            logic w_zero;
            always_comb begin
                w_blank = '0;
                w_zero  = 1'b1;
                for (int i = DIGITS - 1; i >= 1; i--) begin
                    w_zero     = w_zero & (r_scr[4*i +: 4] == 4'd0);
                    w_blank[i] = w_zero & ~r_ovf_scr;
                end
            end
        end else begin : g_blank_off
            assign w_blank = '0;
        end
    endgenerate

    // Datapath: operand capture, shift-add-3 iterations and result publication
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            r_bin      <= '0;
            r_scr      <= '0;
            r_ovf_scr  <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_bin     <= data;
                r_scr     <= '0;
                r_ovf_scr <= 1'b0;
                r_cnt     <= '0;
            end
            if (w_shift) begin
                // Bit leaving the top digit is a carry past 10**DIGITS
                r_scr     <= {w_adj[4*DIGITS-2:0], r_bin[DATA_W-1]};
                r_bin     <= r_bin << 1;
                r_ovf_scr <= r_ovf_scr | w_adj[4*DIGITS-1];
                r_cnt     <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_bcd      <= r_scr;
                r_overflow <= r_ovf_scr;
                r_blank    <= w_blank;
            end
            r_done <= w_finish;
        end
    end

    assign done     = r_done;
    assign bcd      = r_bcd;
    assign blank    = r_blank;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
